// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, mode encodings, state type and GF(2^8) byte helpers.
// The S-box is computed from the field inverse plus the affine map, so no tables are needed.
package aes_pkg;
  localparam int BLOCK_LENGTH = 128;
  localparam int NUM_BYTES = BLOCK_LENGTH / 8;
  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef logic [BLOCK_LENGTH-1:0] state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (and maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = gf_inv(x);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    logic [7:0] t;
    t = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction
endpackage

// File: rtl/aes_cells.sv
// Round-function cells: key_add, SubBytes, InvSubBytes, ShiftRows, InvShiftRows.
// Byte k of the state is bits [127-8k -: 8]; row = k % 4, column = k / 4.
module key_add
  import aes_pkg::*;
(
  input  state_t state,
  input  state_t key,
  output state_t result
);
  assign result = state ^ key;
endmodule

module SubBytes
  import aes_pkg::*;
(
  input  state_t state,
  output state_t result
);
  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
    assign result[BLOCK_LENGTH-1-8*gi -: 8] = sbox(state[BLOCK_LENGTH-1-8*gi -: 8]);
  end
endmodule

module InvSubBytes
  import aes_pkg::*;
(
  input  state_t state,
  output state_t result
);
  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
    assign result[BLOCK_LENGTH-1-8*gi -: 8] = inv_sbox(state[BLOCK_LENGTH-1-8*gi -: 8]);
  end
endmodule

module ShiftRows
  import aes_pkg::*;
(
  input  state_t state,
  output state_t result
);
  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int SRC = ROW + 4 * (((gi / 4) + ROW) % 4);
    assign result[BLOCK_LENGTH-1-8*gi -: 8] = state[BLOCK_LENGTH-1-8*SRC -: 8];
  end
endmodule

module InvShiftRows
  import aes_pkg::*;
(
  input  state_t state,
  output state_t result
);
  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int SRC = ROW + 4 * (((gi / 4) - ROW + 4) % 4);
    assign result[BLOCK_LENGTH-1-8*gi -: 8] = state[BLOCK_LENGTH-1-8*SRC -: 8];
  end
endmodule

// File: rtl/aes_pipe_stage.sv
// Valid/ready register slice: loads whenever it is empty or its content leaves this cycle.
module aes_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;

  assign in_ready  = !valid_reg || out_ready;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;

  // data only moves on a real beat, so a stalled or draining slice keeps its last value
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (in_ready) begin
      valid_reg <= in_valid;
      if (in_valid) data_reg <= in_data;
    end
  end
endmodule

// File: rtl/aes_final_round_pipe.sv
// Elastic AES final round for both directions, selected per beat by in_mode.
// One or two valid/ready slices; mode, tag and (for two slices) the key travel with the state.
module aes_final_round_pipe #(
  parameter int BLOCK_LENGTH = 128,
  parameter int STAGES = 1,
  parameter int TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_mode,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic [BLOCK_LENGTH-1:0] IN,
  input  logic [BLOCK_LENGTH-1:0] KEY,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_mode,
  output logic [TAG_W-1:0]        out_tag,
  output logic [BLOCK_LENGTH-1:0] OUT,
  output logic                    busy
);
  import aes_pkg::*;

  if (BLOCK_LENGTH != aes_pkg::BLOCK_LENGTH) begin : g_bad_length
    $fatal(1, "aes_final_round_pipe: BLOCK_LENGTH must be 128");
  end
  if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
    $fatal(1, "aes_final_round_pipe: STAGES must be 1 or 2");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $fatal(1, "aes_final_round_pipe: TAG_W must be at least 1");
  end

  logic head_ready;

  // nothing is accepted while reset is asserted
  assign in_ready = rst && head_ready;

  if (STAGES == 1) begin : g_one
    localparam int P_W = 1 + TAG_W + BLOCK_LENGTH;
    state_t sb, sr, ka_src, ka, isr, isb, result;
    logic [P_W-1:0] pout;
    logic           v0;

    SubBytes     u_sb  (.state(IN), .result(sb));
    ShiftRows    u_sr  (.state(sb), .result(sr));
    // the single key_add serves the end of encrypt and the start of decrypt
    assign ka_src = (in_mode == MODE_DEC) ? IN : sr;
    key_add      u_ka  (.state(ka_src), .key(KEY), .result(ka));
    InvShiftRows u_isr (.state(ka), .result(isr));
    InvSubBytes  u_isb (.state(isr), .result(isb));
    assign result = (in_mode == MODE_DEC) ? isb : ka;

    aes_pipe_stage #(.WIDTH(P_W)) u_stage0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(head_ready), .in_data({in_mode, in_tag, result}),
      .out_valid(v0), .out_ready(out_ready), .out_data(pout)
    );

    assign out_valid = v0;
    assign out_mode  = pout[P_W-1];
    assign out_tag   = pout[P_W-2 -: TAG_W];
    assign OUT       = pout[BLOCK_LENGTH-1:0];
    assign busy      = v0;
  end else begin : g_two
    localparam int P0_W = 1 + TAG_W + 2 * BLOCK_LENGTH;
    localparam int P1_W = 1 + TAG_W + BLOCK_LENGTH;
    state_t sb, sr, ka_in, isr, s0_next;
    state_t data0, key0, isb, ka_out, s1_next;
    logic [P0_W-1:0] p0;
    logic [P1_W-1:0] p1;
    logic            v0, v1, ready1, mode0;
    logic [TAG_W-1:0] tag0;

    SubBytes     u_sb     (.state(IN), .result(sb));
    ShiftRows    u_sr     (.state(sb), .result(sr));
    key_add      u_ka_in  (.state(IN), .key(KEY), .result(ka_in));
    InvShiftRows u_isr    (.state(ka_in), .result(isr));
    assign s0_next = (in_mode == MODE_DEC) ? isr : sr;

    aes_pipe_stage #(.WIDTH(P0_W)) u_stage0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(head_ready), .in_data({in_mode, in_tag, KEY, s0_next}),
      .out_valid(v0), .out_ready(ready1), .out_data(p0)
    );

    assign mode0 = p0[P0_W-1];
    assign tag0  = p0[P0_W-2 -: TAG_W];
    assign key0  = p0[2*BLOCK_LENGTH-1 -: BLOCK_LENGTH];
    assign data0 = p0[BLOCK_LENGTH-1:0];

    // stage 0 and stage 1 may hold opposite modes, so encrypt needs its own key add here
    InvSubBytes  u_isb    (.state(data0), .result(isb));
    key_add      u_ka_out (.state(data0), .key(key0), .result(ka_out));
    assign s1_next = (mode0 == MODE_DEC) ? isb : ka_out;

    aes_pipe_stage #(.WIDTH(P1_W)) u_stage1 (
      .clk(clk), .rst(rst),
      .in_valid(v0), .in_ready(ready1), .in_data({mode0, tag0, s1_next}),
      .out_valid(v1), .out_ready(out_ready), .out_data(p1)
    );

    assign out_valid = v1;
    assign out_mode  = p1[P1_W-1];
    assign out_tag   = p1[P1_W-2 -: TAG_W];
    assign OUT       = p1[BLOCK_LENGTH-1:0];
    assign busy      = v0 || v1;
  end
endmodule
